// File: rtl/mq_deq_sched.sv
// Dequeue scheduler for the shared-RAM multi-queue FIFO: burst-limited round-robin
// issue, one-cycle read-latency absorption and a 2-entry skid buffer with valid/ready.
module mq_deq_sched #(
    parameter int unsigned MQNUM = 8,
    parameter int unsigned MQBIT = 3,
    parameter int unsigned DWID  = 18,
    parameter int unsigned BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MQNUM-1:0] q_nempty,
    output logic [MQNUM-1:0] q_ren,
    input  logic [DWID-1:0]  q_rdata,
    input  logic [MQNUM-1:0] cfg_en,
    input  logic             stop_req,
    output logic             stop_ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DWID-1:0]  out_data,
    output logic [MQBIT-1:0] out_qid,
    output logic [31:0]      dbg
);

    localparam logic [7:0] BurstMax = 8'(BURST);

    typedef enum logic [2:0] {
        StRun      = 3'd0,
        StStopping = 3'd1,
        StStopped  = 3'd2
    } state_e;

    state_e                 state_q;
    logic [MQBIT-1:0]       rr_ptr_q;
    logic [7:0]             burst_cnt_q;
    logic                   inflight_q;
    logic [MQBIT-1:0]       inflight_qid_q;

    logic [MQBIT+DWID-1:0]  buf_q [2];
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             occ_q;

    logic [MQNUM-1:0]       elig;
    logic                   pop;
    logic [2:0]             level;
    logic                   room;
    logic                   run_ok;
    logic                   grant_any;
    logic                   grant_keep;
    logic [MQBIT-1:0]       grant_idx;
    logic                   issue;

    // q_nempty already reflects a read on the edge after q_ren, so a queue may be
    // granted again in the very next cycle without over-reading its last entry.
    assign elig = q_nempty & cfg_en;

    assign pop = out_valid & out_ready;

    // Entries that will occupy the skid buffer next cycle if nothing new is issued.
    assign level = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign room  = (level < 3'd2);

    assign run_ok = (state_q == StRun) && !stop_req && !rst;

    always_comb begin : arb
        int unsigned      idx;
        logic [MQBIT-1:0] cand;
        grant_any  = 1'b0;
        grant_keep = 1'b0;
        grant_idx  = rr_ptr_q;
        idx        = 0;
        cand       = '0;
        if (elig[rr_ptr_q] && (burst_cnt_q < BurstMax)) begin
            grant_any  = 1'b1;
            grant_keep = 1'b1;
        end else begin
            // Search starts one past the pointer; the last candidate is the pointer itself.
            for (int unsigned k = 1; k <= MQNUM; k++) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= MQNUM) begin
                    idx = idx - MQNUM;
                end
                cand = idx[MQBIT-1:0];
                if (!grant_any && elig[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign issue = run_ok && room && grant_any;

    always_comb begin
        q_ren = '0;
        if (issue) begin
            q_ren[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            rr_ptr_q       <= '0;
            burst_cnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_qid_q <= '0;
            buf_q[0]       <= '0;
            buf_q[1]       <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            occ_q          <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (stop_req) begin
                        state_q <= StStopping;
                    end
                end
                StStopping: begin
                    if (!stop_req) begin
                        state_q <= StRun;
                    end else if (!inflight_q && (occ_q == 2'd0)) begin
                        state_q <= StStopped;
                    end
                end
                StStopped: begin
                    if (!stop_req) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase

            if (issue) begin
                rr_ptr_q       <= grant_idx;
                burst_cnt_q    <= grant_keep ? (burst_cnt_q + 8'd1) : 8'd1;
                inflight_qid_q <= grant_idx;
            end
            inflight_q <= issue;

            // Read data returns one cycle after q_ren; capture it with its queue tag.
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= {inflight_qid_q, q_rdata};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    assign out_valid           = (occ_q != 2'd0);
    assign {out_qid, out_data} = buf_q[rd_ptr_q];

    // Acknowledge falls combinationally as soon as the request is withdrawn.
    assign stop_ack = (state_q == StStopped) && stop_req;

    assign dbg = {16'b0, 5'b0, state_q, 8'(rr_ptr_q)};

endmodule

// File: tb/tb_mq_deq_sched.sv
// Bench for mq_deq_sched: behavioural queue FIFO model, output scoreboard, table of
// arbitration scenarios and hand-written backpressure/stop/mask/reset sequences.
module tb_mq_deq_sched;

    localparam int MQNUM = 8;
    localparam int MQBIT = 3;
    localparam int DWID  = 18;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [MQNUM-1:0] q_nempty = '0;
    logic [MQNUM-1:0] q_ren;
    logic [DWID-1:0]  q_rdata = '0;
    logic [MQNUM-1:0] cfg_en = '1;
    logic             stop_req = 1'b0;
    logic             stop_ack;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [DWID-1:0]  out_data;
    logic [MQBIT-1:0] out_qid;
    logic [31:0]      dbg;

    always #5 clk = ~clk;

    mq_deq_sched #(
        .MQNUM(MQNUM),
        .MQBIT(MQBIT),
        .DWID (DWID),
        .BURST(BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .q_nempty (q_nempty),
        .q_ren    (q_ren),
        .q_rdata  (q_rdata),
        .cfg_en   (cfg_en),
        .stop_req (stop_req),
        .stop_ack (stop_ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_qid  (out_qid),
        .dbg      (dbg)
    );

    typedef struct {
        logic [31:0] cnt;  // entries per queue, one nibble per queue
        logic [7:0]  cfg;
        int          n;
        logic [63:0] seq;  // expected grant order, one nibble per grant, first in [3:0]
    } row_t;

    row_t rows [6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int first_valid = -1;
    int seqn = 0;
    bit sb_en = 1'b0;

    logic [DWID-1:0]       fifo   [MQNUM][$];
    logic [DWID-1:0]       shadow [MQNUM][$];
    logic [MQBIT+DWID-1:0] exp_q [$];
    int                    grant_q [$];
    int                    grant_cyc [$];

    int          held_cnt, unstable, pops0, g0, ren_after;
    logic [17:0] held;
    int          exp_w [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Queue FIFO model: registered not-empty flag, read data one cycle after q_ren.
    always @(posedge clk) begin : model
        logic [MQNUM-1:0] ne;
        cyc++;
        if (rst) begin
            for (int i = 0; i < MQNUM; i++) fifo[i].delete();
            q_nempty <= '0;
        end else begin
            for (int i = 0; i < MQNUM; i++) begin
                if (q_ren[i] && fifo[i].size() != 0) q_rdata <= fifo[i].pop_front();
            end
            for (int i = 0; i < MQNUM; i++) ne[i] = (fifo[i].size() != 0);
            q_nempty <= ne;
        end
    end

    always @(negedge clk) begin : monitor
        int gi;
        logic [MQBIT+DWID-1:0] e;
        if (|q_ren) begin
            check("ren_onehot", 32'($onehot(q_ren)), 32'd1);
            gi = 0;
            for (int i = 0; i < MQNUM; i++) if (q_ren[i]) gi = i;
            grant_q.push_back(gi);
            grant_cyc.push_back(cyc);
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            pop_cnt++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got word %0h, expected no output",
                             {out_qid, out_data});
                end else begin
                    e = exp_q.pop_front();
                    check("sb_word", 32'({out_qid, out_data}), 32'(e));
                end
            end
        end
    end

    task automatic do_reset();
        sb_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        stop_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        grant_q.delete();
        grant_cyc.delete();
        exp_q.delete();
        for (int i = 0; i < MQNUM; i++) shadow[i].delete();
        first_valid = -1;
        sb_en = 1'b1;
    endtask

    task automatic load(input int q, input int n);
        logic [DWID-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = {3'(q), 15'(seqn)};
            seqn++;
            fifo[q].push_back(w);
            shadow[q].push_back(w);
        end
    endtask

    task automatic expect_word(input int q);
        logic [2:0] qq;
        qq = 3'(q);
        if (shadow[q].size() != 0) exp_q.push_back({qq, shadow[q].pop_front()});
    endtask

    task automatic wait_drain(input string name, input int limit);
        int c = 0;
        while (exp_q.size() != 0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{cnt: 32'h0000_000A, cfg: 8'hFF, n: 10, seq: 64'h0};
        rows[1] = '{cnt: 32'h0000_8080, cfg: 8'hFF, n: 16, seq: 64'h3333_1111_3333_1111};
        rows[2] = '{cnt: 32'h0020_0300, cfg: 8'hFF, n: 5,  seq: 64'h0000_0000_0005_5222};
        rows[3] = '{cnt: 32'h0000_0015, cfg: 8'hFF, n: 6,  seq: 64'h0000_0000_0001_0000};
        rows[4] = '{cnt: 32'h0220_0000, cfg: 8'hDF, n: 2,  seq: 64'h0000_0000_0000_0066};
        rows[5] = '{cnt: 32'h5001_0000, cfg: 8'hFF, n: 6,  seq: 64'h0000_0000_0077_7774};
        exp_w = '{7, 7, 0, 0};

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_q_ren", 32'(q_ren), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_stop_ack", 32'(stop_ack), 32'd0);
        check("rst_dbg", dbg, 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_qid", 32'(out_qid), 32'd0);

        // Arbitration table
        for (int r = 0; r < 6; r++) begin
            do_reset();
            cfg_en = rows[r].cfg;
            out_ready = 1'b1;
            for (int q = 0; q < MQNUM; q++) load(q, int'(rows[r].cnt[4*q +: 4]));
            for (int k = 0; k < rows[r].n; k++) expect_word(int'(rows[r].seq[4*k +: 4]));
            wait_drain($sformatf("row%0d", r), 200);
            repeat (3) @(negedge clk);
            check($sformatf("row%0d_grants", r), 32'(grant_q.size()), 32'(rows[r].n));
            for (int k = 0; k < rows[r].n; k++) begin
                if (k < grant_q.size())
                    check($sformatf("row%0d_grant%0d", r, k), 32'(grant_q[k]),
                          32'(rows[r].seq[4*k +: 4]));
            end
            if (grant_q.size() > 0) begin
                check($sformatf("row%0d_no_gap", r),
                      32'(grant_cyc[grant_q.size()-1] - grant_cyc[0]),
                      32'(grant_q.size() - 1));
                check($sformatf("row%0d_latency", r), 32'(first_valid - grant_cyc[0]), 32'd2);
            end
        end

        // Backpressure: two reads fill the skid buffer, then issue stalls
        do_reset();
        cfg_en = 8'hFF;
        out_ready = 1'b0;
        load(2, 6);
        for (int k = 0; k < 6; k++) expect_word(2);
        unstable = 0;
        held = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 4) held = out_data;
            if (c > 4 && out_data !== held) unstable++;
        end
        check("bp_grants", 32'(grant_q.size()), 32'd2);
        check("bp_ren_idle", 32'(q_ren), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_stable", 32'(unstable), 32'd0);
        check("bp_head", 32'({out_qid, out_data}), 32'(exp_q[0]));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain("bp", 60);
        check("bp_total", 32'(grant_q.size()), 32'd6);

        // Stop/drain with one read in flight and one word buffered
        do_reset();
        cfg_en = 8'hFF;
        out_ready = 1'b1;
        load(3, 12);
        for (int k = 0; k < 12; k++) expect_word(3);
        repeat (4) @(posedge clk);
        #1;
        pops0 = pop_cnt;
        g0 = grant_q.size();
        stop_req = 1'b1;
        check("stop_pre_grants", 32'(g0), 32'd3);
        ren_after = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (|q_ren) ren_after++;
            if (c == 1) begin
                check("stop_ack_draining", 32'(stop_ack), 32'd0);
                check("stop_dbg_stopping", dbg, 32'h0000_0103);
            end
        end
        check("stop_no_ren", 32'(ren_after), 32'd0);
        check("stop_ack", 32'(stop_ack), 32'd1);
        check("stop_pops", 32'(pop_cnt - pops0), 32'd2);
        check("stop_dbg_stopped", dbg, 32'h0000_0203);
        check("stop_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        stop_req = 1'b0;
        @(negedge clk);
        check("stop_ack_drop", 32'(stop_ack), 32'd0);
        wait_drain("stop", 80);
        check("stop_total", 32'(grant_q.size()), 32'd12);
        if (grant_q.size() > g0) check("stop_resume_q", 32'(grant_q[g0]), 32'd3);

        // cfg_en mask, then wrap from rr_ptr=6 through q7 to q0
        do_reset();
        cfg_en = 8'h7F;
        out_ready = 1'b1;
        load(7, 2);
        load(0, 3);
        for (int k = 0; k < 3; k++) expect_word(0);
        wait_drain("mask", 40);
        repeat (3) @(negedge clk);
        check("mask_grants", 32'(grant_q.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            if (k < grant_q.size()) check($sformatf("mask_grant%0d", k), 32'(grant_q[k]), 32'd0);
        @(posedge clk); #1;
        load(6, 1);
        expect_word(6);
        wait_drain("mask_q6", 40);
        repeat (2) @(negedge clk);
        check("mask_rr6", dbg, 32'h0000_0006);
        @(posedge clk); #1;
        cfg_en = 8'hFF;
        load(0, 2);
        expect_word(7);
        expect_word(7);
        expect_word(0);
        expect_word(0);
        wait_drain("wrap", 40);
        repeat (2) @(negedge clk);
        check("wrap_grants", 32'(grant_q.size()), 32'd8);
        for (int k = 0; k < 4; k++)
            if (k + 4 < grant_q.size())
                check($sformatf("wrap_grant%0d", k), 32'(grant_q[k+4]), 32'(exp_w[k]));

        // Reset in the middle of a burst
        do_reset();
        sb_en = 1'b0;
        cfg_en = 8'hFF;
        load(0, 10);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst_pre_ren", 32'(q_ren), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_q_ren", 32'(q_ren), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_dbg", dbg, 32'd0);
        check("midrst_data", 32'({out_qid, out_data}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
